// File: rtl/ir_pkg.sv
// Shared definitions for the instruction-register interface: opcode bytes,
// mnemonic select encoding, issuer state encoding and the operand predicate.
// Used by ir_encoder, ir_opcode_rom and the IR decoder.
package ir_pkg;

  localparam logic [7:0] OPC_LD   = 8'hFF;
  localparam logic [7:0] OPC_ADD  = 8'hFE;
  localparam logic [7:0] OPC_SUB  = 8'hFD;
  localparam logic [7:0] OPC_AND  = 8'hFC;
  localparam logic [7:0] OPC_OR   = 8'hFB;
  localparam logic [7:0] OPC_SHL  = 8'hF9;
  localparam logic [7:0] OPC_XOR  = 8'hF2;
  localparam logic [7:0] OPC_HALT = 8'hF8;

  typedef enum logic [2:0] {
    SEL_LD   = 3'd0,
    SEL_ADD  = 3'd1,
    SEL_SUB  = 3'd2,
    SEL_AND  = 3'd3,
    SEL_OR   = 3'd4,
    SEL_SHL  = 3'd5,
    SEL_XOR  = 3'd6,
    SEL_HALT = 3'd7
  } op_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPC  = 2'd1,
    ST_OPND = 2'd2
  } state_e;

  // SHL and HALT are single-byte; every other mnemonic carries an operand.
  function automatic logic has_operand(input op_sel_e op);
    case (op)
      SEL_SHL, SEL_HALT: return 1'b0;
      default:           return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ir_opcode_rom.sv
// Combinational mnemonic-to-opcode map with the operand-taking flag.
module ir_opcode_rom
  import ir_pkg::*;
(
  input  logic [2:0] op_sel,
  output logic [7:0] opcode,
  output logic       has_opnd
);

  op_sel_e sel;

  assign sel = op_sel_e'(op_sel);

  // Look up the opcode byte and operand flag for the selected mnemonic.
  always_comb begin
    opcode   = OPC_LD;
    has_opnd = has_operand(sel);
    case (sel)
      SEL_LD:   opcode = OPC_LD;
      SEL_ADD:  opcode = OPC_ADD;
      SEL_SUB:  opcode = OPC_SUB;
      SEL_AND:  opcode = OPC_AND;
      SEL_OR:   opcode = OPC_OR;
      SEL_SHL:  opcode = OPC_SHL;
      SEL_XOR:  opcode = OPC_XOR;
      SEL_HALT: opcode = OPC_HALT;
      default:  opcode = OPC_LD;
    endcase
  end

endmodule

// File: rtl/ir_encoder.sv
// Instruction issuer: accepts a mnemonic over REQ/RDY, drives the opcode byte
// with IIR and, when IR_ENC_OPERAND_EN is defined, the operand byte with WRD.
// Without IR_ENC_OPERAND_EN every instruction is single-byte and WRD is 0.
// Strobes and D decode straight from the state register so reset drops them
// immediately; latched opcode/operand are data and carry no reset.
module ir_encoder
  import ir_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [2:0]       OP_SEL,
  input  logic [7:0]       OPERAND,
  input  logic             REQ,
  output logic             RDY,
  output logic [7:0]       D,
  output logic             IIR,
  output logic             WRD,
  input  logic             DST_RDY,
  output logic             HALTED,
  input  logic             RESUME,
  output logic [CNT_W-1:0] INSTR_CNT
);

  state_e           state_q, state_d;
  logic             halted_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       opc_p1;
  logic [7:0]       rom_opc;
  logic             rom_hasop;
  logic             xfer;
  logic             last_acc;
  logic             halt_acc;

  ir_opcode_rom u_rom (
    .op_sel   (OP_SEL),
    .opcode   (rom_opc),
    .has_opnd (rom_hasop)
  );

`ifdef IR_ENC_OPERAND_EN
  logic [7:0] opnd_p1;
  logic       hasop_p1;
`else
  logic       unused_opnd;
  assign unused_opnd = ^{OPERAND, rom_hasop};
`endif

  assign xfer     = REQ & RDY;
  assign halt_acc = (state_q == ST_OPC) & DST_RDY & (opc_p1 == OPC_HALT);

  assign RDY       = (state_q == ST_IDLE) & ~halted_q;
  assign IIR       = (state_q == ST_OPC);
`ifdef IR_ENC_OPERAND_EN
  assign WRD       = (state_q == ST_OPND);
  assign D         = IIR ? opc_p1 : (WRD ? opnd_p1 : 8'h00);
`else
  assign WRD       = 1'b0;
  assign D         = IIR ? opc_p1 : 8'h00;
`endif
  assign HALTED    = halted_q;
  assign INSTR_CNT = cnt_q;

  // Next-state decode; last_acc marks acceptance of an instruction's final byte.
  always_comb begin
    state_d  = state_q;
    last_acc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xfer) state_d = ST_OPC;
      end
      ST_OPC: begin
        if (DST_RDY) begin
`ifdef IR_ENC_OPERAND_EN
          if (hasop_p1) begin
            state_d = ST_OPND;
          end else begin
            state_d  = ST_IDLE;
            last_acc = 1'b1;
          end
`else
          state_d  = ST_IDLE;
          last_acc = 1'b1;
`endif
        end
      end
`ifdef IR_ENC_OPERAND_EN
      ST_OPND: begin
        if (DST_RDY) begin
          state_d  = ST_IDLE;
          last_acc = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state: FSM, halt flag (HALT acceptance wins over RESUME), counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (halt_acc)    halted_q <= 1'b1;
      else if (RESUME) halted_q <= 1'b0;
      if (last_acc)    cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Capture the encoded request at the transfer edge.
  always_ff @(posedge CLK) begin
    if (xfer) begin
      opc_p1   <= rom_opc;
`ifdef IR_ENC_OPERAND_EN
      opnd_p1  <= OPERAND;
      hasop_p1 <= rom_hasop;
`endif
    end
  end

endmodule

// File: tb/tb_ir_encoder.sv
// Directed bench for ir_encoder; expectations follow IR_ENC_OPERAND_EN.
module tb_ir_encoder;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [2:0] OP_SEL = 3'd0;
  logic [7:0] OPERAND = 8'h00;
  logic       REQ = 1'b0;
  logic       RDY;
  logic [7:0] D;
  logic       IIR;
  logic       WRD;
  logic       DST_RDY = 1'b1;
  logic       HALTED;
  logic       RESUME = 1'b0;
  logic [7:0] INSTR_CNT;

  int errs   = 0;
  int checks = 0;
  logic [7:0] exp_cnt = 8'h00;

  always #5 CLK = ~CLK;

  ir_encoder #(.CNT_W(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .OP_SEL    (OP_SEL),
    .OPERAND   (OPERAND),
    .REQ       (REQ),
    .RDY       (RDY),
    .D         (D),
    .IIR       (IIR),
    .WRD       (WRD),
    .DST_RDY   (DST_RDY),
    .HALTED    (HALTED),
    .RESUME    (RESUME),
    .INSTR_CNT (INSTR_CNT)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Wait (bounded) for RDY, then present one request for one edge.
  task automatic issue(input logic [2:0] sel, input logic [7:0] opnd);
    int n;
    n = 0;
    while (RDY !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (RDY !== 1'b1) chk("rdy_timeout", 32'd0, 32'd1);
    OP_SEL  = sel;
    OPERAND = opnd;
    REQ     = 1'b1;
    tick();
    REQ     = 1'b0;
  endtask

  initial begin
    int nwrap;
    #1 RST = 1'b1;
    #1;
    chk("rst_rdy", RDY, 1);
    chk("rst_d", D, 8'h00);
    chk("rst_iir", IIR, 0);
    chk("rst_wrd", WRD, 0);
    chk("rst_halted", HALTED, 0);
    chk("rst_cnt", INSTR_CNT, 8'h00);
    tick();
    tick();
    RST = 1'b0;

    // ADD 3C with downstream always ready
    issue(3'd1, 8'h3C);
    chk("add_iir", IIR, 1);
    chk("add_opc", D, 8'hFE);
    chk("add_wrd0", WRD, 0);
    chk("add_rdy0", RDY, 0);
    tick();
`ifdef IR_ENC_OPERAND_EN
    chk("add_wrd", WRD, 1);
    chk("add_iir0", IIR, 0);
    chk("add_opnd", D, 8'h3C);
    chk("add_cnt_mid", INSTR_CNT, 8'h00);
    tick();
`endif
    exp_cnt++;
    chk("add_idle_iir", IIR, 0);
    chk("add_idle_wrd", WRD, 0);
    chk("add_idle_d", D, 8'h00);
    chk("add_idle_rdy", RDY, 1);
    chk("add_cnt", INSTR_CNT, exp_cnt);

    // SHL: single byte, RDY back two cycles after acceptance
    issue(3'd5, 8'hAA);
    chk("shl_opc", D, 8'hF9);
    chk("shl_iir", IIR, 1);
    chk("shl_wrd", WRD, 0);
    chk("shl_rdy0", RDY, 0);
    tick();
    exp_cnt++;
    chk("shl_wrd_after", WRD, 0);
    chk("shl_d_after", D, 8'h00);
    chk("shl_rdy", RDY, 1);
    chk("shl_cnt", INSTR_CNT, exp_cnt);

    // LD with three stall cycles: opcode held four cycles
    DST_RDY = 1'b0;
    issue(3'd0, 8'h5A);
    for (int i = 0; i < 4; i++) begin
      chk("ld_hold_iir", IIR, 1);
      chk("ld_hold_d", D, 8'hFF);
      chk("ld_hold_wrd", WRD, 0);
      if (i == 3) DST_RDY = 1'b1;
      tick();
    end
`ifdef IR_ENC_OPERAND_EN
    chk("ld_wrd", WRD, 1);
    chk("ld_opnd", D, 8'h5A);
    tick();
`endif
    exp_cnt++;
    chk("ld_done_iir", IIR, 0);
    chk("ld_cnt", INSTR_CNT, exp_cnt);

    // HALT with REQ held: no further transfer while halted
    OP_SEL = 3'd7;
    REQ    = 1'b1;
    tick();
    OP_SEL = 3'd1;
    chk("halt_opc", D, 8'hF8);
    chk("halt_iir", IIR, 1);
    chk("halt_pre", HALTED, 0);
    tick();
    exp_cnt++;
    chk("halt_set", HALTED, 1);
    chk("halt_rdy0", RDY, 0);
    chk("halt_cnt", INSTR_CNT, exp_cnt);
    tick();
    chk("halt_hold", HALTED, 1);
    chk("halt_no_xfer", IIR, 0);
    chk("halt_rdy_hold", RDY, 0);
    REQ    = 1'b0;
    RESUME = 1'b1;
    tick();
    RESUME = 1'b0;
    chk("resume_clr", HALTED, 0);
    chk("resume_rdy", RDY, 1);
    RESUME = 1'b1;
    tick();
    RESUME = 1'b0;
    chk("resume_idle", HALTED, 0);
    chk("resume_idle_iir", IIR, 0);

    // HALT accepted in the same cycle as RESUME: set wins
    issue(3'd7, 8'h00);
    RESUME = 1'b1;
    chk("halt2_iir", IIR, 1);
    tick();
    RESUME = 1'b0;
    exp_cnt++;
    chk("halt2_set", HALTED, 1);
    chk("halt2_cnt", INSTR_CNT, exp_cnt);
    RESUME = 1'b1;
    tick();
    RESUME = 1'b0;
    chk("halt2_clr", HALTED, 0);

    // Counter wrap with back-to-back single-byte instructions
    nwrap = 256 - int'(exp_cnt);
    for (int i = 0; i < nwrap; i++) begin
      issue(3'd5, 8'h00);
      tick();
      exp_cnt++;
      chk("wrap_run", INSTR_CNT, exp_cnt);
    end
    chk("wrap_zero", INSTR_CNT, 8'h00);

    // Reset in the middle of an instruction
    issue(3'd2, 8'h77);
`ifdef IR_ENC_OPERAND_EN
    tick();
    chk("mid_wrd", WRD, 1);
    chk("mid_opnd", D, 8'h77);
`else
    chk("mid_iir", IIR, 1);
    chk("mid_opc", D, 8'hFD);
`endif
    #2 RST = 1'b1;
    #1;
    chk("abort_wrd", WRD, 0);
    chk("abort_iir", IIR, 0);
    chk("abort_d", D, 8'h00);
    chk("abort_cnt", INSTR_CNT, 8'h00);
    tick();
    RST = 1'b0;
    tick();
    tick();
    chk("post_rst_cnt", INSTR_CNT, 8'h00);
    chk("post_rst_rdy", RDY, 1);
    issue(3'd6, 8'h11);
    chk("post_rst_opc", D, 8'hF2);
    tick();
`ifdef IR_ENC_OPERAND_EN
    chk("post_rst_opnd", D, 8'h11);
    tick();
`endif
    chk("post_rst_cnt1", INSTR_CNT, 8'h01);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ir_encoder.md
# ir_encoder

Instruction issuer for the model computer: the transmitting end of the instruction-register interface. Accepts a mnemonic select plus operand over a valid/ready handshake, encodes it to the 8-bit opcode the IR decoder recognises, and drives it onto the instruction bus with the IR load strobe. In the two-byte configuration it also drives an operand byte. It sits between the program sequencer or test loader and the IR/data-register bus.

## Interface
Parameters:
- CNT_W, 8, width of the issued-instruction counter.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- OP_SEL  in  3  mnemonic: 0 LD, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SHL, 6 XOR, 7 HALT.
- OPERAND  in  8  operand byte; sampled with the request.
- REQ  in  1  request valid.
- RDY  out  1  ready to accept. A transfer occurs when REQ&RDY at a rising edge.
- D  out  8  instruction bus byte.
- IIR  out  1  opcode byte valid on D; doubles as the IR load enable.
- WRD  out  1  operand byte valid on D.
- DST_RDY  in  1  downstream accepts the current byte at an edge where (IIR|WRD)&DST_RDY.
- HALTED  out  1  a HALT has been issued.
- RESUME  in  1  clears the halted condition.
- INSTR_CNT  out  CNT_W  count of completed instructions.

## Operation
- Encoding: LD 8'hFF, ADD 8'hFE, SUB 8'hFD, AND 8'hFC, OR 8'hFB, SHL 8'hF9, XOR 8'hF2, HALT 8'hF8.
- States:
  - IDLE: RDY = ~HALTED. On a transfer, latch the opcode and operand, then go to OPC.
  - OPC: IIR=1 and D=opcode. Hold until DST_RDY. Then go to OPND if the instruction takes an operand; otherwise go to IDLE.
  - OPND: WRD=1 and D=operand. Hold until DST_RDY, then go to IDLE.
- Operand-taking instructions: LD, ADD, SUB, AND, OR, XOR. SHL and HALT are single-byte.
- D is 8'h00 whenever IIR and WRD are both 0. IIR and WRD are never high together.
- The byte and strobe are held stable while DST_RDY is low. Stall length is unbounded.
- INSTR_CNT increments once when the last byte of an instruction is accepted. It wraps from all-ones to 0.
- HALTED sets when the HALT opcode byte is accepted.
  - While HALTED is set, RDY=0.
  - RESUME clears HALTED at the next edge.
  - RESUME has no effect when HALTED is clear.
- Reset values: state IDLE; RDY=1, D=0, IIR=0, WRD=0, HALTED=0, INSTR_CNT=0.
- Reset asserted mid-instruction aborts it immediately. Strobes drop asynchronously, and a partial instruction is not counted.

## Timing
- RDY is a registered state decode and never depends on REQ.
- A transfer at edge N puts IIR and the opcode on D after edge N; they are valid from cycle N+1.
- With DST_RDY held high:
  - A single-byte instruction occupies cycles N+1 only. RDY=1 again in N+2.
  - A two-byte instruction puts the opcode in N+1 and the operand in N+2. RDY=1 in N+3.
- Best throughput is one single-byte instruction every 2 cycles.
- INSTR_CNT and HALTED update at the edge that accepts the final byte.
- RESUME in the same cycle as HALT acceptance: HALTED still sets, and the set takes priority over RESUME.

## Configuration
- IR_ENC_OPERAND_EN defined: two-byte LD/ALU instructions as above.
- IR_ENC_OPERAND_EN undefined:
  - Every instruction is single-byte and the OPND state is absent.
  - OPERAND is ignored, and WRD is tied to 0.

## Structure
- Shared package ir_pkg holds:
  - the eight opcode constants;
  - the OP_SEL enumeration;
  - the state enumeration;
  - a function has_operand(op).
- The IR decoder uses the same opcode constants from ir_pkg.
- Sub-module ir_opcode_rom: combinational map from OP_SEL to opcode byte plus the has_operand flag. The FSM, registers and counter live in ir_encoder.

## Test plan
- Reset, then REQ with OP_SEL=1, OPERAND=8'h3C, DST_RDY=1 -> D=FE with IIR for 1 cycle, then D=3C with WRD for 1 cycle; INSTR_CNT becomes 1.
- OP_SEL=5 (SHL) -> D=F9 with IIR for one cycle; no WRD; RDY high 2 cycles after acceptance.
- OP_SEL=0 (LD), DST_RDY low for 3 cycles -> D=FF with IIR held 4 cycles; operand follows only after acceptance.
- OP_SEL=7 (HALT) -> D=F8, HALTED=1, RDY=0 while REQ held. RESUME pulse -> RDY=1 next cycle.
- Issue 256 single-byte instructions (CNT_W=8) -> INSTR_CNT wraps to 0.
- RST asserted during the OPND cycle -> WRD and D drop at once, and INSTR_CNT is unchanged.
